// File: rtl/gcd_upd.sv
// gcd_upd - public-key candidate qualifier for RSA key generation.
//
// Samples a candidate exponent and the totient, computes their gcd with a
// multi-cycle binary (Stein) engine, and publishes the candidate as the public
// key only when gcd == 1 and 1 < candidate < totient. While start_0 stays high
// the block keeps resampling, so the outputs track operand changes.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   start_0     in   1  level enable; sample and recompute while high
//   lfsr_nu     in  32  candidate exponent (unsigned)
//   y           in  32  totient / modulus operand (unsigned)
//   gcd_out     out 32  registered gcd of the last sampled pair
//   public_key  out 32  registered qualified key, or 0
//   done        out  1  one-cycle pulse coincident with an output update

module gcd_upd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_0,
    input  logic [31:0] lfsr_nu,
    input  logic [31:0] y,
    output logic [31:0] gcd_out,
    output logic [31:0] public_key,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] a, b, cand, tot, result;
    logic [5:0]  k;

    logic [31:0] a_nxt, b_nxt, cand_nxt, tot_nxt, result_nxt;
    logic [5:0]  k_nxt;
    logic [31:0] gcd_nxt, key_nxt;
    logic        done_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_0) state_nxt = CALC;
            CALC: if (a == '0 || b == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        a_nxt      = a;
        b_nxt      = b;
        k_nxt      = k;
        cand_nxt   = cand;
        tot_nxt    = tot;
        result_nxt = result;
        gcd_nxt    = gcd_out;
        key_nxt    = public_key;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start_0) begin
                    a_nxt    = lfsr_nu;
                    b_nxt    = y;
                    k_nxt    = '0;
                    cand_nxt = lfsr_nu;
                    tot_nxt  = y;
                end
            end
            CALC: begin
                // One Stein step per cycle; the first matching rule wins.
                if (a == '0) begin
                    result_nxt = b << k;
                end else if (b == '0) begin
                    result_nxt = a << k;
                end else if (!a[0] && !b[0]) begin
                    a_nxt = a >> 1;
                    b_nxt = b >> 1;
                    k_nxt = k + 6'd1;
                end else if (!a[0]) begin
                    a_nxt = a >> 1;
                end else if (!b[0]) begin
                    b_nxt = b >> 1;
                end else if (a >= b) begin
                    // Difference of two odd values is even, so halve it now.
                    a_nxt = (a - b) >> 1;
                end else begin
                    b_nxt = (b - a) >> 1;
                end
            end
            DONE: begin
                gcd_nxt  = result;
                key_nxt  = (result == 32'd1 && cand > 32'd1 && cand < tot) ? cand : '0;
                done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a          <= '0;
            b          <= '0;
            k          <= '0;
            cand       <= '0;
            tot        <= '0;
            result     <= '0;
            gcd_out    <= '0;
            public_key <= '0;
            done       <= 1'b0;
        end else begin
            a          <= a_nxt;
            b          <= b_nxt;
            k          <= k_nxt;
            cand       <= cand_nxt;
            tot        <= tot_nxt;
            result     <= result_nxt;
            gcd_out    <= gcd_nxt;
            public_key <= key_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_gcd_upd.sv
// tb_gcd_upd - self-checking bench for gcd_upd.
// Expected gcd comes from Euclid's algorithm; the key rule is applied directly.

module tb_gcd_upd;

    logic        clk;
    logic        rst_n;
    logic        start_0;
    logic [31:0] lfsr_nu;
    logic [31:0] y;
    logic [31:0] gcd_out;
    logic [31:0] public_key;
    logic        done;

    int n_checks;
    int n_fail;

    localparam logic [31:0] TOT = 32'h048B1420;

    gcd_upd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_0    (start_0),
        .lfsr_nu    (lfsr_nu),
        .y          (y),
        .gcd_out    (gcd_out),
        .public_key (public_key),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] z);
        logic [31:0] p, q, t;
        p = x;
        q = z;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_key(input logic [31:0] nu, input logic [31:0] tv);
        if (ref_gcd(nu, tv) == 1 && nu > 1 && nu < tv) return nu;
        return 32'd0;
    endfunction

    // Bounded wait for a done pulse; outputs must not move while waiting.
    task automatic wait_done(input int budget, output bit got);
        logic [31:0] pg, pk;
        pg  = gcd_out;
        pk  = public_key;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                n_checks++;
                if (gcd_out !== pg || public_key !== pk) begin
                    n_fail++;
                    $display("FAIL stable: gcd_out=%h public_key=%h, required %h %h", gcd_out, public_key, pg, pk);
                end
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    // Let any computation in flight finish, then launch a fresh sample.
    task automatic launch(input logic [31:0] nu, input logic [31:0] tv);
        start_0 = 1'b0;
        repeat (70) @(negedge clk);
        lfsr_nu = nu;
        y       = tv;
        start_0 = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        start_0 = 1'b0;
        lfsr_nu = '0;
        y       = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (gcd_out !== 32'd0) begin n_fail++; $display("FAIL reset_gcd: got %h, required 0", gcd_out); end
        n_checks++;
        if (public_key !== 32'd0) begin n_fail++; $display("FAIL reset_key: got %h, required 0", public_key); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] nus [8];
        logic [31:0] tvs [8];
        bit got;
        nus = '{32'd2, 32'd7, 32'd48, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1, TOT + 32'd1};
        tvs = '{TOT,   TOT,   32'd18, 32'd0, 32'hFFFFFFFE, TOT,   TOT,   TOT};
        for (int i = 0; i < 8; i++) begin
            launch(nus[i], tvs[i]);
            wait_done(67, got);
            if (got) begin
                n_checks++;
                if (gcd_out !== ref_gcd(nus[i], tvs[i])) begin
                    n_fail++;
                    $display("FAIL dir_gcd[%0d]: got %h, required %h", i, gcd_out, ref_gcd(nus[i], tvs[i]));
                end
                n_checks++;
                if (public_key !== ref_key(nus[i], tvs[i])) begin
                    n_fail++;
                    $display("FAIL dir_key[%0d]: got %h, required %h", i, public_key, ref_key(nus[i], tvs[i]));
                end
                @(negedge clk);
                n_checks++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL dir_pulse[%0d]: done=%b, required 0", i, done); end
            end
        end
    endtask

    task automatic test_track;
        bit got;
        launch(32'd2, TOT);
        wait_done(67, got);
        n_checks++;
        if (gcd_out !== 32'd2) begin n_fail++; $display("FAIL track_first: got %h, required 2", gcd_out); end
        // DUT is idle while done is high, so the next edge samples the new value.
        lfsr_nu = 32'd3;
        wait_done(67, got);
        n_checks++;
        if (gcd_out !== 32'd3) begin n_fail++; $display("FAIL track_gcd: got %h, required 3", gcd_out); end
        n_checks++;
        if (public_key !== 32'd0) begin n_fail++; $display("FAIL track_key: got %h, required 0", public_key); end
    endtask

    task automatic test_reset_mid;
        bit got;
        lfsr_nu = 32'd7;
        y       = TOT;
        start_0 = 1'b1;
        wait_done(140, got);
        wait_done(67, got);
        n_checks++;
        if (public_key !== 32'd7) begin n_fail++; $display("FAIL pre_reset_key: got %h, required 7", public_key); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gcd_out !== 32'd0) begin n_fail++; $display("FAIL midreset_gcd: got %h, required 0", gcd_out); end
        n_checks++;
        if (public_key !== 32'd0) begin n_fail++; $display("FAIL midreset_key: got %h, required 0", public_key); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b, required 0", done); end
        @(negedge clk);
        lfsr_nu = 32'd48;
        y       = 32'd18;
        rst_n   = 1'b1;
        wait_done(67, got);
        n_checks++;
        if (gcd_out !== 32'd6) begin n_fail++; $display("FAIL post_reset_gcd: got %h, required 6", gcd_out); end
        n_checks++;
        if (public_key !== 32'd0) begin n_fail++; $display("FAIL post_reset_key: got %h, required 0", public_key); end
    endtask

    task automatic test_start_drop;
        bit got;
        int pulses;
        launch(32'd7, TOT);
        @(negedge clk);
        start_0 = 1'b0;
        wait_done(66, got);
        n_checks++;
        if (gcd_out !== 32'd1) begin n_fail++; $display("FAIL drop_gcd: got %h, required 1", gcd_out); end
        n_checks++;
        if (public_key !== 32'd7) begin n_fail++; $display("FAIL drop_key: got %h, required 7", public_key); end
        pulses = 0;
        repeat (150) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL drop_extra_done: got %0d pulses, required 0", pulses); end
    endtask

    task automatic test_random;
        bit got;
        logic [31:0] nu, tv;
        for (int i = 0; i < 24; i++) begin
            tv = $urandom;
            nu = $urandom;
            case (i % 3)
                0: ;
                1: begin tv = tv & 32'hFF; nu = nu & 32'hFF; end
                default: nu = (tv == 0) ? nu : nu % tv;
            endcase
            launch(nu, tv);
            wait_done(67, got);
            if (got) begin
                n_checks++;
                if (gcd_out !== ref_gcd(nu, tv)) begin
                    n_fail++;
                    $display("FAIL rnd_gcd[%0d] nu=%h y=%h: got %h, required %h", i, nu, tv, gcd_out, ref_gcd(nu, tv));
                end
                n_checks++;
                if (public_key !== ref_key(nu, tv)) begin
                    n_fail++;
                    $display("FAIL rnd_key[%0d] nu=%h y=%h: got %h, required %h", i, nu, tv, public_key, ref_key(nu, tv));
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_directed;
        test_track;
        test_reset_mid;
        test_start_drop;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_upd.md
# gcd_upd

Public-key candidate qualifier for the RSA key-generation path. It takes a candidate exponent (`lfsr_nu`, normally from the LFSR) and the totient `y`. It computes gcd(`lfsr_nu`, `y`) with a multi-cycle binary (Stein) GCD engine. It publishes the candidate as `public_key` only when the two are coprime and 1 < `lfsr_nu` < `y`.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start_0` input 1: level enable; while high, the block repeatedly samples operands and recomputes.
- `lfsr_nu` input 32: candidate exponent, unsigned.
- `y` input 32: totient / modulus operand, unsigned.
- `gcd_out` output 32: registered gcd of the last sampled operand pair.
- `public_key` output 32: registered qualified key, or 0.
- `done` output 1: one-cycle pulse when `gcd_out` and `public_key` update.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, with `start_0`=1 at a clock edge:
  - latch a←`lfsr_nu`, b←`y`, k←0;
  - save `lfsr_nu` and `y` as `cand` and `tot`;
  - go to CALC.
- IDLE, with `start_0`=0: stay in IDLE; outputs hold.
- CALC: exactly one step per cycle, first matching rule wins:
  - a==0: result←b<<k, go to DONE;
  - b==0: result←a<<k, go to DONE;
  - a and b both even: a>>=1, b>>=1, k++;
  - a even: a>>=1;
  - b even: b>>=1;
  - otherwise (both odd): if a≥b then a←(a−b)>>1, else b←(b−a)>>1.
- Width rules: a and b are 32-bit unsigned; k is 6 bits; the result shift cannot overflow, because the true gcd fits in 32 bits.
- DONE: load gcd_out←result.
  - If result==1 and 1<`cand`<`tot` (unsigned compares): public_key←`cand`.
  - Otherwise: public_key←0.
  - Pulse `done`=1 and return to IDLE.
- Re-evaluation: if `start_0` is still high in IDLE, a new computation starts on the next edge. The outputs therefore track operand changes while enabled.
- Operand changes during CALC are ignored until the next sample.
- Deasserting `start_0` mid-CALC does not abort; the current result still completes and publishes.
- Degenerate operands:
  - gcd(0,0)=0;
  - gcd(x,0)=gcd(0,x)=x;
  - `lfsr_nu`=1 gives gcd 1 but public_key 0;
  - `lfsr_nu`≥`y` gives public_key 0 regardless of gcd.

## Timing
- Reset (async, any state) forces IDLE with gcd_out=0, public_key=0, done=0, and internal a/b/k/cand/tot=0; any computation in flight is aborted.
- The first sampling edge is the first rising edge with rst_n=1 and start_0=1.
- Latency:
  - each CALC step reduces bitlen(a)+bitlen(b) by at least 1, so CALC takes at most 65 cycles;
  - outputs update at most 67 edges after the sampling edge (sample, ≤65 CALC, DONE);
  - the next sample occurs one cycle after DONE.
- `gcd_out` and `public_key` change only at the DONE edge, or asynchronously at reset. They are stable otherwise.
- `done` is high for exactly one cycle per completed computation.

## Test plan
- y=0x048B1420 (76223520), lfsr_nu=2, start_0 held high 100 cycles -> gcd_out=2, public_key=0, done pulses within 67 cycles.
- Same y, lfsr_nu=7 -> gcd_out=1, public_key=7.
- While start_0 stays high, change lfsr_nu from 2 to 3 -> gcd_out updates to 3, public_key stays 0.
- Boundaries with y=76223520:
  - lfsr_nu=0 -> gcd_out=76223520, public_key=0;
  - lfsr_nu=1 -> gcd_out=1, public_key=0;
  - lfsr_nu=y+1 (coprime) -> gcd_out=1, public_key=0.
- lfsr_nu=48, y=18 -> gcd_out=6.
- lfsr_nu=0, y=0 -> gcd_out=0, public_key=0.
- lfsr_nu=0xFFFFFFFF, y=0xFFFFFFFE -> gcd_out=1, public_key=0 because lfsr_nu>y.
- Assert rst_n=0 mid-CALC -> all outputs 0 immediately.
- After release with start_0 held high, a fresh computation completes correctly.
- Deassert start_0 one cycle after sampling -> the result still publishes once; no further done pulses occur.
